// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the FIFO-draining UART transmitter.
//   tx_state_t           - transmitter FSM state encoding
//   UART_DATA_BITS       - data bits per frame
//   DEFAULT_CLKS_PER_BIT - 50 MHz / 115200 baud
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter for the UART transmitter.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - restart the bit period (asserted on every FSM state entry)
//   run   - count while a serial bit is on the line
//   tick  - one-cycle pulse on the last clock of a bit period
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  assign tick = run && (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (run)
      cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: UART transmitter draining the read side of a FIFO.
// Pops one word whenever the FIFO is non-empty and enable is high, and sends
// its low byte as an 8N1/8E1 frame (LSB first) with 1 or 2 stop bits.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   enable     - permit starting new frames (a frame in flight always finishes)
//   fifo_empty - FIFO empty flag
//   fifo_rd    - single-cycle pop strobe, registered
//   fifo_dout  - FIFO read data, valid the cycle after fifo_rd (bits above 7 ignored)
//   tx         - serial line, idle high, registered
//   busy       - high from FETCH through the last stop bit, registered
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_WIDTH   = 32,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  tx,
  output logic                  busy
);

  tx_state_t                 state, state_nxt;
  logic [2:0]                bit_idx, idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      tx_nxt;
  logic                      tick, run, clear;
  logic                      more;

  // Upper FIFO bits are deliberately not transmitted (FIFO_WIDTH > 8 assumed).
  logic unused_hi;
  assign unused_hi = ^fifo_dout[FIFO_WIDTH-1:UART_DATA_BITS];

  assign more  = enable && !fifo_empty;
  assign run   = (state == START) || (state == DATA) ||
                 (state == PARITY) || (state == STOP);
  assign clear = (state_nxt != state);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    case (state)
      IDLE:   if (more) state_nxt = FETCH;
      FETCH:  state_nxt = LOAD;
      LOAD:   state_nxt = START;
      START:  if (tick) state_nxt = DATA;
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1))
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          else
            idx_nxt = bit_idx + 3'd1;
        end
      end
      PARITY: if (tick) state_nxt = STOP;
      STOP: begin
        // bit_idx doubles as the stop-bit counter
        if (tick) begin
          if (bit_idx == 3'(STOP_BITS - 1))
            state_nxt = more ? FETCH : IDLE;
          else
            idx_nxt = bit_idx + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) idx_nxt = '0;

    // Line level is derived from the upcoming state so tx stays registered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[idx_nxt];
      PARITY:  tx_nxt = ^shreg;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      fifo_rd <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= idx_nxt;
      if (state == LOAD) shreg <= fifo_dout[UART_DATA_BITS-1:0];
      tx      <= tx_nxt;
      fifo_rd <= (state_nxt == FETCH);
      busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench: two DUTs (8N1 and 8E2, CLKS_PER_BIT=4) each fed by a queue-based FIFO
// model; expected line waveforms are built from the frame format.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic        e0 = 1'b1, e1 = 1'b1;
  logic        rd0, rd1, tx0, tx1, busy0, busy1;
  logic [31:0] d0 = '0, d1 = '0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          pops0 = 0, pops1 = 0, bad_rd = 0;
  int          n_chk = 0, n_fail = 0;

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .FIFO_WIDTH(32), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(e0),
    .fifo_rd(rd0), .fifo_dout(d0), .tx(tx0), .busy(busy0));

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .FIFO_WIDTH(32), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(e1),
    .fifo_rd(rd1), .fifo_dout(d1), .tx(tx1), .busy(busy1));

  // FIFO models: registered empty flag, data valid the cycle after a pop.
  always @(posedge clk) begin
    if (rd0) begin
      pops0 <= pops0 + 1;
      if (e0) bad_rd <= bad_rd + 1;
      if (q0.size() > 0) d0 <= q0.pop_front();
    end
    e0 <= (q0.size() == 0);
  end

  always @(posedge clk) begin
    if (rd1) begin
      pops1 <= pops1 + 1;
      if (e1) bad_rd <= bad_rd + 1;
      if (q1.size() > 0) d1 <= q1.pop_front();
    end
    e1 <= (q1.size() == 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic txo(input int w);
    return (w != 0) ? tx1 : tx0;
  endfunction

  function automatic logic bsy(input int w);
    return (w != 0) ? busy1 : busy0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int w, input logic [31:0] v);
    if (w != 0) q1.push_back(v);
    else q0.push_back(v);
  endtask

  // Advance until the start bit appears; lat = clocks waited.
  task automatic wait_start(input int w, input string tag, output int lat);
    lat = 0;
    while (txo(w) !== 1'b0 && lat < 300) begin
      tick();
      lat++;
    end
    chk({tag, " start seen"}, 32'(lat < 300), 32'd1);
  endtask

  // Called on the first START cycle; checks the whole frame, ends on the
  // first cycle after the last stop bit. drop_at >= 0 lowers enable then.
  task automatic expect_frame(input int w, input logic [31:0] word, input string tag,
                              input int drop_at);
    logic [7:0] b;
    int         pe, sb, nb, cyc;
    logic       lv;
    b   = word[7:0];
    pe  = (w != 0) ? 1 : 0;
    sb  = (w != 0) ? 2 : 1;
    nb  = 1 + 8 + pe + sb;
    cyc = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == 0)                lv = 1'b0;
      else if (i <= 8)           lv = b[i-1];
      else if (pe == 1 && i == 9) lv = ^b;
      else                       lv = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (cyc == drop_at) enable = 1'b0;
        chk($sformatf("%s bit%0d cyc%0d {tx,busy}", tag, i, cyc),
            {30'd0, txo(w), bsy(w)}, {30'd0, lv, 1'b1});
        tick();
        cyc++;
      end
    end
  endtask

  initial begin
    int lat, p, n;
    logic [31:0] rw;

    // Reset with words already queued and enable low
    push(0, 32'h11); push(1, 32'h22);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset tx0", 32'(tx0), 1); chk("reset rd0", 32'(rd0), 0); chk("reset busy0", 32'(busy0), 0);
      chk("reset tx1", 32'(tx1), 1); chk("reset busy1", 32'(busy1), 0);
    end
    rst = 1'b0;
    tick();
    chk("post-reset tx0", 32'(tx0), 1); chk("post-reset rd0", 32'(rd0), 0);
    chk("post-reset busy0", 32'(busy0), 0); chk("post-reset rd1", 32'(rd1), 0);
    q0.delete(); q1.delete();
    tick(); tick();

    // Single 0x55, 8N1: latency, waveform, busy fall, one pop
    enable = 1'b1;
    p = pops0;
    push(0, 32'h55);
    wait_start(0, "single", lat);
    chk("single latency", 32'(lat), 32'd4);  // 1 clk for empty flag + 3
    expect_frame(0, 32'h55, "single 55", -1);
    chk("single busy fell", 32'(busy0), 0);
    chk("single idle tx", 32'(tx0), 1);
    chk("single pops", 32'(pops0 - p), 1);

    // Back-to-back A5, 3C
    tick(); tick();
    p = pops0;
    push(0, 32'hA5); push(0, 32'h3C);
    wait_start(0, "b2b", lat);
    expect_frame(0, 32'hA5, "b2b A5", -1);
    n = 0;
    while (tx0 === 1'b1 && n < 20) begin
      chk("b2b gap busy", 32'(busy0), 1);
      tick();
      n++;
    end
    chk("b2b gap after stop", 32'(n), 32'd2);
    expect_frame(0, 32'h3C, "b2b 3C", -1);
    tick();
    chk("b2b idle busy", 32'(busy0), 0);
    chk("b2b pops", 32'(pops0 - p), 2);

    // 8E2, word with upper bits set
    p = pops1;
    push(1, 32'hFFFF_FF07);
    wait_start(1, "parity", lat);
    expect_frame(1, 32'hFFFF_FF07, "parity 07", -1);
    chk("parity busy at 48", 32'(busy1), 0);
    chk("parity pops", 32'(pops1 - p), 1);

    // Random burst on 8E2
    tick();
    p = pops1;
    for (int k = 0; k < 4; k++) push(1, $urandom);
    begin
      logic [31:0] exp_q[$];
      exp_q = q1;
      wait_start(1, "rand", lat);
      for (int k = 0; k < 4; k++) begin
        expect_frame(1, exp_q[k], $sformatf("rand%0d", k), -1);
        if (k < 3) begin
          n = 0;
          while (tx1 === 1'b1 && n < 20) begin tick(); n++; end
          chk($sformatf("rand gap%0d", k), 32'(n), 32'd2);
        end
      end
    end
    tick();
    chk("rand idle busy", 32'(busy1), 0);
    chk("rand pops", 32'(pops1 - p), 4);

    // enable dropped mid-DATA with 3 queued
    tick();
    p = pops0;
    rw = $urandom;
    push(0, rw); push(0, $urandom); push(0, $urandom);
    wait_start(0, "endrop", lat);
    expect_frame(0, rw, "endrop", 6);
    for (int i = 0; i < 12; i++) tick();
    chk("endrop idle tx", 32'(tx0), 1);
    chk("endrop idle busy", 32'(busy0), 0);
    chk("endrop pops", 32'(pops0 - p), 1);
    chk("endrop left", 32'(q0.size()), 2);

    // Reset during data bit 3 of 0x00
    q0.delete();
    tick(); tick();
    p = pops0;
    rw = $urandom;
    enable = 1'b1;
    push(0, 32'h00); push(0, rw);
    wait_start(0, "rstmid", lat);
    for (int i = 0; i < 4 + 3 * CPB; i++) tick();
    chk("rstmid in bit3 low", 32'(tx0), 0);
    rst = 1'b1;
    tick();
    chk("rstmid tx", 32'(tx0), 1);
    chk("rstmid busy", 32'(busy0), 0);
    chk("rstmid rd", 32'(rd0), 0);
    rst = 1'b0;
    wait_start(0, "rstmid next", lat);
    chk("rstmid next latency", 32'(lat), 32'd3);
    expect_frame(0, rw, "rstmid next", -1);
    tick();
    chk("rstmid pops", 32'(pops0 - p), 2);
    chk("rstmid idle busy", 32'(busy0), 0);

    chk("no pop while empty", 32'(bad_rd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
